// File: rtl/dff_debounce_pkg.sv
// Shared encodings and default sizing for the debounce stage and its bench.
package dff_debounce_pkg;

    localparam int unsigned STABLE_DEF = 4;
    localparam int unsigned CNT_W_DEF  = 4;
    localparam int unsigned PCNT_W_DEF = 8;

    typedef enum logic [1:0] {
        S_LOW    = 2'd0,
        S_WAIT_H = 2'd1,
        S_HIGH   = 2'd2,
        S_WAIT_L = 2'd3
    } state_t;

endpackage

// File: rtl/dff_debounce_wrap_counter.sv
// Free-running modulo-2^W event counter with enable and async active-high reset.
module wrap_counter #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/dff_debounce.sv
// Debounces the registered D-FF output: a level is accepted after STABLE identical
// samples, with one-cycle RISE/FALL pulses and a wrapping count of accepted rises.
module dff_debounce
    import dff_debounce_pkg::*;
#(
    parameter int unsigned STABLE = STABLE_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned PCNT_W = PCNT_W_DEF
) (
    input  logic              i_ck,
    input  logic              i_rst,
    input  logic              i_d,
    output logic              o_lvl,
    output logic              o_rise,
    output logic              o_fall,
    output logic [PCNT_W-1:0] o_pcnt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE - 1);

    if (STABLE < 2 || STABLE > (2 ** CNT_W) - 1) begin : g_bad_stable
        $error("dff_debounce: STABLE=%0d out of range for CNT_W=%0d", STABLE, CNT_W);
    end

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_lvl;
    logic             r_rise;
    logic             r_fall;
    logic             w_rise_en;

    // Accepting a high level; drives the PCNT increment on the same edge as RISE.
    assign w_rise_en = (r_state == S_WAIT_H) && i_d && (r_cnt == CNT_LAST);

    always_ff @(posedge i_ck or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
            r_lvl   <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                S_LOW: begin
                    if (i_d) begin
                        r_state <= S_WAIT_H;
                        r_cnt   <= CNT_W'(1);
                    end else begin
                        r_cnt <= '0;
                    end
                end
                S_WAIT_H: begin
                    if (!i_d) begin
                        r_state <= S_LOW;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_HIGH;
                        r_cnt   <= '0;
                        r_lvl   <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (!i_d) begin
                        r_state <= S_WAIT_L;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                S_WAIT_L: begin
                    if (i_d) begin
                        r_state <= S_HIGH;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_LOW;
                        r_cnt   <= '0;
                        r_lvl   <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_LOW;
                    r_cnt   <= '0;
                    r_lvl   <= 1'b0;
                end
            endcase
        end
    end

    wrap_counter #(
        .W(PCNT_W)
    ) u_pcnt (
        .i_clk (i_ck),
        .i_rst (i_rst),
        .i_en  (w_rise_en),
        .o_cnt (o_pcnt)
    );

    assign o_lvl  = r_lvl;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: tb/tb_dff_debounce.sv
// Directed bench for dff_debounce: reset, glitch rejection, clean edges, async reset,
// PCNT wrap (2-bit instance) and alternating input.
module tb_dff_debounce;
    import dff_debounce_pkg::*;

    logic       ck = 1'b0;
    logic       rst = 1'b1;
    logic       d = 1'b1;
    logic       lvl, rise, fall;
    logic [7:0] pcnt;
    logic       lvl_w, rise_w, fall_w;
    logic [1:0] pcnt_w;

    int errors = 0;
    int checks = 0;

    always #5 ck = ~ck;

    dff_debounce #(
        .STABLE(STABLE_DEF), .CNT_W(CNT_W_DEF), .PCNT_W(PCNT_W_DEF)
    ) dut (
        .i_ck(ck), .i_rst(rst), .i_d(d),
        .o_lvl(lvl), .o_rise(rise), .o_fall(fall), .o_pcnt(pcnt)
    );

    dff_debounce #(
        .STABLE(STABLE_DEF), .CNT_W(CNT_W_DEF), .PCNT_W(2)
    ) dut_w (
        .i_ck(ck), .i_rst(rst), .i_d(d),
        .o_lvl(lvl_w), .o_rise(rise_w), .o_fall(fall_w), .o_pcnt(pcnt_w)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int e_lvl, input int e_rise,
                           input int e_fall, input int e_pcnt);
        chk({tag, ".lvl"},  32'(lvl),  e_lvl);
        chk({tag, ".rise"}, 32'(rise), e_rise);
        chk({tag, ".fall"}, 32'(fall), e_fall);
        chk({tag, ".pcnt"}, 32'(pcnt), e_pcnt);
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        tick();
    endtask

    int rise_cnt;
    int fall_cnt;
    int both_hi;
    int act;

    initial begin
        // Reset held with D=1: outputs stay cleared, including across the 5 ns edge.
        #3;  chk_all("rst_a", 0, 0, 0, 0);
        #7;  chk_all("rst_b", 0, 0, 0, 0);
        #2;  rst = 1'b0;
        tick(); tick(); tick();
        chk_all("pre_rise", 0, 0, 0, 0);
        tick();
        chk_all("rise", 1, 1, 0, 1);
        tick();
        chk_all("rise_end", 1, 0, 0, 1);

        // Low glitch of 3 samples while high.
        d = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("glitch_lo", 1, 0, 0, 1);
        end
        d = 1'b1;
        tick();
        chk_all("glitch_lo_end", 1, 0, 0, 1);

        // Clean fall: FALL on 4th edge, exactly one cycle wide.
        d = 1'b0;
        tick(); tick(); tick();
        chk_all("pre_fall", 1, 0, 0, 1);
        tick();
        chk_all("fall", 0, 0, 1, 1);
        tick();
        chk_all("fall_end", 0, 0, 0, 1);

        // High glitch of 3 samples while low.
        d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("glitch_hi", 0, 0, 0, 1);
        end
        d = 1'b0;
        tick();
        chk_all("glitch_hi_end", 0, 0, 0, 1);

        // Async reset mid-count: PCNT clears before the next edge.
        d = 1'b1;
        tick(); tick();
        #2;  rst = 1'b1;
        #1;  chk_all("mid_rst", 0, 0, 0, 0);
        #9;  rst = 1'b0;
        tick(); tick(); tick();
        chk_all("mid_rst_pre", 0, 0, 0, 0);
        tick();
        chk_all("mid_rst_rise", 1, 1, 0, 1);

        // Reset during the RISE cycle kills the pulse immediately, none on release.
        #2;  rst = 1'b1;
        #1;  chk_all("rst_in_pulse", 0, 0, 0, 0);
        d = 1'b0;
        #9;  rst = 1'b0;
        tick();
        chk_all("rst_release", 0, 0, 0, 0);

        // D=0 after reset: no activity.
        for (int i = 0; i < 6; i++) tick();
        chk_all("idle_low", 0, 0, 0, 0);

        // PCNT wrap on 2-bit instance: 5 press/release cycles.
        pulse_reset();
        rise_cnt = 0; fall_cnt = 0; both_hi = 0;
        for (int c = 0; c < 5; c++) begin
            d = 1'b1;
            for (int i = 0; i < 4; i++) begin
                tick();
                rise_cnt += 32'(rise_w);
                fall_cnt += 32'(fall_w);
                if (rise_w && fall_w) both_hi++;
            end
            chk("wrap.pcnt_w", 32'(pcnt_w), (c + 1) % 4);
            chk("wrap.pcnt",   32'(pcnt),   c + 1);
            d = 1'b0;
            for (int i = 0; i < 4; i++) begin
                tick();
                rise_cnt += 32'(rise_w);
                fall_cnt += 32'(fall_w);
                if (rise_w && fall_w) both_hi++;
            end
            chk("wrap.lvl_low", 32'(lvl_w), 0);
        end
        tick();
        chk("wrap.rises", rise_cnt, 5);
        chk("wrap.falls", fall_cnt, 5);
        chk("wrap.overlap", both_hi, 0);

        // Alternating D for 40 cycles from low, then 20 from high.
        act = 0;
        for (int i = 0; i < 40; i++) begin
            d = (i % 2 == 0);
            tick();
            if (lvl || rise || fall) act++;
        end
        chk("alt_low.activity", act, 0);
        chk("alt_low.pcnt", 32'(pcnt), 5);

        d = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk_all("alt_setup", 1, 0, 0, 6);
        act = 0;
        for (int i = 0; i < 20; i++) begin
            d = (i % 2 == 1);
            tick();
            if (!lvl || rise || fall) act++;
        end
        chk("alt_high.activity", act, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
